// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit - multiply/divide unit for the execute stage of the MIPS core.
//
// Owns the HI/LO register pair. mult/multu/div/divu run for a fixed number
// of cycles, during which busy is high. mthi/mtlo complete in one cycle.
// Results are computed from operands latched at start and written to HI/LO
// on the final busy edge.
//
// Optional feature macro: MD_UNIT_MADD_EN enables madd (op 6) and maddu
// (op 7). Without it, ops 6/7 are NOPs and no accumulator adder exists.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   start  in   1   one-cycle request qualifying op
//   op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//                   6 madd, 7 maddu
//   A      in  32   rs operand (forwarded)
//   B      in  32   rt operand (forwarded)
//   busy   out  1   multi-cycle operation in flight
//   HI     out 32   HI register
//   LO     out 32   LO register
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | accepts start; mthi/mtlo write immediately
// ST_BUSY | counting down; all starts ignored; write HI/LO at count 1
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [2:0]  op_q,    op_d;

    // Products from the latched operands
    logic [63:0] a_sext, b_sext, prod_s, prod_u;

    assign a_sext = {{32{a_q[31]}}, a_q};
    assign b_sext = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sext * b_sext;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes so the -2^31 / -1 case wraps cleanly to
    // quotient 0x80000000, remainder 0 instead of overflowing.
    logic [31:0] a_mag, b_mag, quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;

    assign a_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign quo_m = a_mag / b_mag;
    assign rem_m = a_mag % b_mag;
    assign quo_s = (a_q[31] ^ b_q[31]) ? (~quo_m + 32'd1) : quo_m;
    assign rem_s = a_q[31] ? (~rem_m + 32'd1) : rem_m;
    assign quo_u = a_q / b_q;
    assign rem_u = a_q % b_q;

`ifdef MD_UNIT_MADD_EN
    // Accumulates onto HI/LO as they stand at completion, wrapping mod 2^64
    logic [63:0] acc_s, acc_u;

    assign acc_s = {hi_q, lo_q} + prod_s;
    assign acc_u = {hi_q, lo_q} + prod_u;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = MULT_CNT;
                            state_d = ST_BUSY;
                        end
                        3'd2, 3'd3: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = DIV_CNT;
                            state_d = ST_BUSY;
                        end
                        3'd4: hi_d = A;
                        3'd5: lo_d = A;
`ifdef MD_UNIT_MADD_EN
                        3'd6, 3'd7: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = MULT_CNT;
                            state_d = ST_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                    case (op_q)
                        3'd0: {hi_d, lo_d} = prod_s;
                        3'd1: {hi_d, lo_d} = prod_u;
                        // Divide by zero still burns full latency, but leaves HI/LO alone
                        3'd2: if (b_q != 32'd0) {hi_d, lo_d} = {rem_s, quo_s};
                        3'd3: if (b_q != 32'd0) {hi_d, lo_d} = {rem_u, quo_u};
`ifdef MD_UNIT_MADD_EN
                        3'd6: {hi_d, lo_d} = acc_s;
                        3'd7: {hi_d, lo_d} = acc_u;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MC;
            3'd2, 3'd3: return DC;
`ifdef MD_UNIT_MADD_EN
            3'd6, 3'd7: return MC;
`endif
            default:    return 0;
        endcase
    endfunction

    // Reference model: plain 64-bit integer arithmetic on the ISA rules
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int              ia, ib;
        longint          sa, sb, q, rm;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        ia = int'(a);
        ib = int'(b);
        sa = longint'(ia);
        sb = longint'(ib);
        ua = {32'd0, a};
        ub = {32'd0, b};
        acc = {m_hi, m_lo};
        case (o)
            3'd0: {m_hi, m_lo} = sa * sb;
            3'd1: {m_hi, m_lo} = ua * ub;
            3'd2: if (b != 32'd0) begin
                q  = sa / sb;
                rm = sa % sb;
                m_lo = q[31:0];
                m_hi = rm[31:0];
            end
            3'd3: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
`ifdef MD_UNIT_MADD_EN
            3'd6: {m_hi, m_lo} = acc + 64'(sa * sb);
            3'd7: {m_hi, m_lo} = acc + 64'(ua * ub);
`endif
            default: ;
        endcase
    endtask

    // Issue one op, scramble A/B while busy, optionally poke illegal starts
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, input string tag);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        model_apply(o, a, b);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            A = $urandom;
            B = $urandom;
            if (intrude && cycles == 3) begin
                start = 1'b1;
                op    = 3'd0;
            end else if (intrude && cycles == 5) begin
                start = 1'b1;
                op    = 3'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles(o)));
        check({tag, " hilo"}, {HI, LO}, {m_hi, m_lo});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {HI, LO}, 64'd0);
        reset = 1'b1;

        // Async reset mid-multiply
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, "pre_mthi");
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, "pre_mtlo");
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (8) @(negedge clk);
        check("post_rst busy", 64'(busy), 64'd0);
        check("post_rst no_late_write", {HI, LO}, 64'd0);

        // Directed multiplies
        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult");
        check("mult const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "multu");
        check("multu const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

        // Directed divides
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        check("div const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, "divu_by0");
        check("divu_by0 const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf const", {HI, LO}, 64'h0000_0000_8000_0000);

        // Back-to-back mthi / mtlo
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        check("mthi hi", 64'(HI), 64'h1234_5678);
        check("mthi busy", 64'(busy), 64'd0);
        op = 3'd5; A = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo hilo", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo busy", 64'(busy), 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // Starts during an in-flight divide are dropped
        run_op(3'd2, 32'd100, 32'd7, 1'b1, "div_intrude");
        check("div_intrude const", {HI, LO}, 64'h0000_0002_0000_000E);

        // madd/maddu behaviour (or NOP when disabled)
        run_op(3'd4, 32'd0, 32'd0, 1'b0, "madd_setup_hi");
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_setup_lo");
        run_op(3'd7, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MD_UNIT_MADD_EN
        check("maddu const", {HI, LO}, 64'h0000_0001_0000_0000);
`else
        check("maddu nop const", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        // Randomised ops against the model
        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFF_FFFF;
            else if (sel == 2) ra = 32'h8000_0000;
            else if (sel == 3) rb = 32'($urandom_range(1, 9));
            run_op(ro, ra, rb, (sel == 4), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
